// File: rtl/axis_detector_packer_pkg.sv
// ============================================================================
// Module      : axis_detector_packer_pkg
// Description : Shared constants and state encoding for the detector packer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package axis_detector_packer_pkg;

    localparam logic [7:0]  C_HDR_MAGIC = 8'hA5;
    localparam int unsigned C_NUM_BEATS = 5;
    localparam int unsigned C_BEAT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic logic [31:0] make_header(
        input logic [7:0] magic,
        input logic [7:0] seq,
        input logic [6:0] popcnt
    );
        return {magic, seq, 9'd0, popcnt};
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_detector_packer_popcount64.sv
// ============================================================================
// Module      : popcount64
// Description : Combinational count of set bits in a 64-bit word (0..64).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module popcount64 (
    input  logic [63:0] i_data,
    output logic [6:0]  o_count
);

    logic [6:0] w_sum;

    always_comb begin
        w_sum = 7'd0;
        for (int i = 0; i < 64; i++) begin
            w_sum = w_sum + {6'd0, i_data[i]};
        end
    end

    assign o_count = w_sum;

endmodule

`default_nettype wire

// File: rtl/axis_detector_packer.sv
// ============================================================================
// Module      : axis_detector_packer
// Description : Accepts 128-bit hit events and emits 5-beat 32-bit packets.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axis_detector_packer
    import axis_detector_packer_pkg::*;
#(
    parameter logic [7:0] HDR_MAGIC = C_HDR_MAGIC
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [31:0]  sts_data
);

    state_t                r_state;
    state_t                w_next;
    logic [C_BEAT_W-1:0]   r_beat;
    logic [7:0]            r_seq;
    logic [127:0]          r_event;
    logic [6:0]            r_popcnt;
    logic [31:0]           r_sts;
    logic                  r_s_ready;
    logic [6:0]            w_popcnt;
    logic                  w_accept;
    logic                  w_beat_hs;
    logic                  w_last_beat;
    logic [31:0]           w_tdata;

    popcount64 u_popcount (
        .i_data  (r_event[63:0]),
        .o_count (w_popcnt)
    );

    assign w_accept    = s_axis_tvalid && r_s_ready;
    assign w_beat_hs   = (r_state == SEND) && m_axis_tready;
    assign w_last_beat = (r_beat == C_BEAT_W'(C_NUM_BEATS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    w_next = SEND;
            SEND:    if (w_beat_hs && w_last_beat) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ready is registered so it stays low while reset is held and rises on the first edge after.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_s_ready <= 1'b0;
            r_beat    <= '0;
            r_seq     <= 8'd0;
            r_event   <= '0;
            r_popcnt  <= 7'd0;
            r_sts     <= 32'd0;
        end else begin
            r_state   <= w_next;
            r_s_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_event <= s_axis_tdata;
            end
            if (r_state == CALC) begin
                r_popcnt <= w_popcnt;
                r_beat   <= '0;
            end else if (w_beat_hs) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    r_seq  <= r_seq + 8'd1;
                    r_sts  <= r_sts + 32'd1;
                end else begin
                    r_beat <= r_beat + C_BEAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_tdata = 32'd0;
        case (r_beat)
            3'd0:    w_tdata = make_header(HDR_MAGIC, r_seq, r_popcnt);
            3'd1:    w_tdata = r_event[95:64];
            3'd2:    w_tdata = r_event[127:96];
            3'd3:    w_tdata = r_event[31:0];
            3'd4:    w_tdata = r_event[63:32];
            default: w_tdata = 32'd0;
        endcase
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = (r_state == SEND);
    assign m_axis_tlast  = (r_state == SEND) && w_last_beat;
    assign m_axis_tdata  = w_tdata;
    assign sts_data      = r_sts;

endmodule

`default_nettype wire

// File: tb/tb_axis_detector_packer.sv
// ============================================================================
// Module      : tb_axis_detector_packer
// Description : Self-checking bench: vector table, reference scoreboard, corners.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_axis_detector_packer;
    import axis_detector_packer_pkg::*;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic [31:0]  sts_data;

    axis_detector_packer #(.HDR_MAGIC(C_HDR_MAGIC)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .sts_data      (sts_data)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- reference scoreboard ----------------
    logic [31:0] exp_q[$];
    int          model_done;
    int          pop_idx;
    int          n_acc;
    int          n_pop;
    int          acc_cyc;
    bit          busy;
    bit          chk_spacing = 1'b0;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_mvalid;
    logic [31:0] last_hdr;

    function automatic void model_push(input logic [127:0] ev);
        logic [7:0] seq;
        logic [6:0] pc;
        seq = 8'(model_done % 256);
        pc  = 7'($countones(ev[63:0]));
        exp_q.push_back({C_HDR_MAGIC, seq, 9'd0, pc});
        exp_q.push_back(ev[95:64]);
        exp_q.push_back(ev[127:96]);
        exp_q.push_back(ev[31:0]);
        exp_q.push_back(ev[63:32]);
    endfunction

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            model_done  = 0;
            pop_idx     = 0;
            n_acc       = 0;
            n_pop       = 0;
            busy        = 1'b0;
            prev_stall  = 1'b0;
            prev_mvalid = 1'b0;
        end else begin
            check32("sts_data", sts_data, 32'(model_done));
            if (busy) check32("s_tready_busy", {31'd0, s_tready}, 32'd0);
            if (prev_stall) begin
                check32("stall_valid", {31'd0, m_tvalid}, 32'd1);
                check32("stall_data", m_tdata, prev_data);
                check32("stall_last", {31'd0, m_tlast}, {31'd0, prev_last});
            end
            if (m_tvalid && !prev_mvalid) check32("latency", 32'(cyc - acc_cyc), 32'd2);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("extra_beat");
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check32("beat_data", m_tdata, e);
                    check32("beat_last", {31'd0, m_tlast}, {31'd0, (pop_idx == C_NUM_BEATS - 1)});
                    if (pop_idx == 0) last_hdr = m_tdata;
                    n_pop++;
                    if (pop_idx == C_NUM_BEATS - 1) begin
                        pop_idx    = 0;
                        model_done = model_done + 1;
                        busy       = 1'b0;
                    end else begin
                        pop_idx = pop_idx + 1;
                    end
                end
            end
            if (s_tvalid && s_tready) begin
                if (chk_spacing && n_acc > 0) check32("spacing", 32'(cyc - acc_cyc), 32'd7);
                acc_cyc = cyc;
                n_acc   = n_acc + 1;
                model_push(s_tdata);
                busy    = 1'b1;
            end
            prev_stall  = m_tvalid && !m_tready;
            prev_data   = m_tdata;
            prev_last   = m_tlast;
            prev_mvalid = m_tvalid;
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef logic [4:0][31:0] words_t;

    typedef struct {
        logic [127:0] data;
        words_t       exp;
    } vec_t;

    vec_t tbl[3];

    task automatic do_reset();
        @(posedge aclk);
        #1 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic send_one(input logic [127:0] d);
        bit got;
        got      = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge aclk);
            if (s_tready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("send_accept");
        @(posedge aclk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic collect(input int n, output words_t w, output logic [4:0] l);
        w = '0;
        l = '0;
        for (int k = 0; k < n; k++) begin
            bit got;
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge aclk);
                if (m_tvalid && m_tready) begin
                    w[k] = m_tdata;
                    l[k] = m_tlast;
                    got  = 1'b1;
                    break;
                end
            end
            if (!got) begin
                timeout_fail("collect_beat");
                return;
            end
        end
    endtask

    task automatic drain();
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(posedge aclk);
            #1;
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("drain");
    endtask

    initial begin
        words_t     w;
        logic [4:0] l;
        bit         done;

        tbl[0].data = {64'h0000000000000010, 64'h8000000000000001};
        tbl[0].exp  = {32'h80000000, 32'h00000001, 32'h00000000, 32'h00000010, 32'hA5000002};
        tbl[1].data = {64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF};
        tbl[1].exp  = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01234567, 32'h89ABCDEF, 32'hA5000040};
        tbl[2].data = {64'hDEADBEEF00000000, 64'h0000000000000000};
        tbl[2].exp  = {32'h00000000, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hA5000000};

        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check32("rst_s_tready", {31'd0, s_tready}, 32'd0);
        check32("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check32("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        check32("rst_sts", sts_data, 32'd0);
        @(negedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1 check32("ready_after_reset", {31'd0, s_tready}, 32'd1);

        // Vector table, each entry from a fresh reset
        for (int i = 0; i < 3; i++) begin
            do_reset();
            m_tready = 1'b1;
            send_one(tbl[i].data);
            collect(5, w, l);
            for (int k = 0; k < 5; k++) begin
                check32($sformatf("tbl%0d_word%0d", i, k), w[k], tbl[i].exp[k]);
                check32($sformatf("tbl%0d_last%0d", i, k), {31'd0, l[k]}, {31'd0, (k == 4)});
            end
            repeat (2) @(posedge aclk);
            #1 check32($sformatf("tbl%0d_sts", i), sts_data, 32'd1);
        end

        // 257 back-to-back events with s_tvalid held high
        do_reset();
        chk_spacing = 1'b1;
        m_tready    = 1'b1;
        s_tvalid    = 1'b1;
        done        = 1'b0;
        for (int t = 0; t < 257 * 7 + 50; t++) begin
            @(posedge aclk);
            #1;
            if (n_acc >= 257) begin
                done = 1'b1;
                break;
            end
            s_tdata = {$urandom, $urandom, $urandom, $urandom};
        end
        s_tvalid = 1'b0;
        if (!done) timeout_fail("b2b_accepts");
        drain();
        chk_spacing = 1'b0;
        check32("b2b_accepts", 32'(n_acc), 32'd257);
        check32("b2b_sts", sts_data, 32'd257);
        check32("b2b_last_seq", {24'd0, last_hdr[23:16]}, 32'd0);

        // Random stalls over 100 events
        do_reset();
        done = 1'b0;
        for (int t = 0; t < 100 * 40; t++) begin
            @(posedge aclk);
            #1;
            if (n_acc >= 100) begin
                done = 1'b1;
                break;
            end
            m_tready = ($urandom_range(0, 99) < 60);
            s_tvalid = ($urandom_range(0, 99) < 50);
            s_tdata  = {$urandom, $urandom, $urandom, $urandom};
        end
        s_tvalid = 1'b0;
        if (!done) timeout_fail("rand_accepts");
        drain();
        check32("rand_words", 32'(n_pop), 32'd500);
        check32("rand_sts", sts_data, 32'd100);

        // m_axis_tready toggling every cycle
        do_reset();
        for (int e = 0; e < 4; e++) begin
            s_tdata  = {$urandom, $urandom, $urandom, $urandom};
            s_tvalid = 1'b1;
            done     = 1'b0;
            for (int t = 0; t < 60; t++) begin
                @(posedge aclk);
                #1;
                m_tready = ~m_tready;
                if (n_acc > e) s_tvalid = 1'b0;
                if (n_acc > e && !busy) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) timeout_fail("toggle_packet");
        end
        drain();
        check32("toggle_words", 32'(n_pop), 32'd20);

        // Reset pulsed after beat 2 accepted
        do_reset();
        m_tready = 1'b1;
        send_one({$urandom, $urandom, $urandom, $urandom});
        collect(3, w, l);
        @(posedge aclk);
        #1 m_tready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check32("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check32("midrst_tlast", {31'd0, m_tlast}, 32'd0);
        check32("midrst_sts", sts_data, 32'd0);
        m_tready = 1'b1;
        repeat (2) @(negedge aclk);
        check32("midrst_no_beats", {31'd0, m_tvalid}, 32'd0);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        send_one(tbl[0].data);
        collect(5, w, l);
        check32("midrst_next_hdr", w[0], 32'hA5000002);
        repeat (2) @(posedge aclk);
        #1 check32("midrst_next_sts", sts_data, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_detector_packer.md
AXIS_DETECTOR_PACKER -- requirements
Module: axis_detector_packer

Interface
REQ-001 SHALL have parameter HDR_MAGIC, default 8'hA5, meaning the constant in header bits [31:24].
REQ-002 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-003 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port s_axis_tdata, input, 128, an event: [127:64] timestamp, [63:0] hit map.
REQ-005 SHALL have port s_axis_tvalid, input, 1, event valid.
REQ-006 SHALL have port s_axis_tready, output, 1, the block accepts an event.
REQ-007 SHALL have port m_axis_tdata, output, 32, packed word.
REQ-008 SHALL have port m_axis_tvalid, output, 1, word valid.
REQ-009 SHALL have port m_axis_tready, input, 1, downstream accepts the word.
REQ-010 SHALL have port m_axis_tlast, output, 1, last word of a packet.
REQ-011 SHALL have port sts_data, output, 32, count of completed packets, wrapping.

Function
REQ-012 SHALL use a state machine with states IDLE, CALC and SEND.
REQ-013 SHALL drive s_axis_tready high only in IDLE.
REQ-014 SHALL, in IDLE on s_axis_tvalid high, register the 128-bit event and go to CALC on the next edge.
REQ-015 SHALL, in CALC, register the 7-bit popcount of the hit map (0..64) and go to SEND with beat counter 0, taking exactly one cycle.
REQ-016 SHALL emit 5 beats per packet, in this order:
- beat 0: header = {HDR_MAGIC, seq[7:0], 9'd0, popcount[6:0]}
- beat 1: timestamp [31:0]
- beat 2: timestamp [63:32]
- beat 3: hit map [31:0]
- beat 4: hit map [63:32]
REQ-017 SHALL hold m_axis_tvalid high throughout SEND and low in IDLE and CALC.
REQ-018 SHALL keep m_axis_tdata and m_axis_tlast stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-019 SHALL advance the beat counter only on m_axis_tvalid and m_axis_tready both high.
REQ-020 SHALL assert m_axis_tlast only on beat 4.
REQ-021 SHALL, on beat 4 handshake, return to IDLE, increment seq by 1 (8-bit wrap, 8'hFF -> 8'h00) and increment sts_data by 1 (32-bit wrap).
REQ-022 SHALL give a minimum latency of 2 cycles from the input handshake edge to the first m_axis_tvalid.
REQ-023 SHALL reach a peak throughput of one event per 7 cycles when m_axis_tready is held high.
REQ-024 SHALL pack an all-zero hit map normally, with popcount 0 and no filtering.
REQ-025 SHALL not accept a new event while a packet is in CALC or SEND; s_axis_tvalid held high is accepted on the first IDLE cycle.
REQ-026 SHALL tolerate m_axis_tready toggling on every cycle without loss or duplication of beats.

Reset
REQ-027 SHALL, while aresetn is low, asynchronously force:
- state IDLE, beat counter 0, seq 0
- event and popcount registers 0, sts_data 0
- m_axis_tvalid 0, m_axis_tlast 0, s_axis_tready 0
REQ-028 SHALL drive s_axis_tready high on the first clock edge after aresetn deasserts.
REQ-029 SHALL, on reset during SEND, abandon the partial packet without emitting remaining beats; after reset the next packet has seq 0.

Structure
REQ-030 SHALL place the header magic, beat count (5) and state encodings in a shared header of constants included by the packer and its bench.
REQ-031 SHALL implement the popcount as sub-module popcount64: combinational, 64-bit in, 7-bit out, registered by the parent in CALC.

Verification
REQ-032 SHALL cover a single event tdata={64'h0000000000000010, 64'h8000000000000001} with tready=1 -> words A5000002, 00000010, 00000000, 00000001, 80000000; tlast on the 5th; sts_data=1.
REQ-033 SHALL cover an all-ones hit map -> header popcount field 7'd64 (header A5000040 for the first packet).
REQ-034 SHALL cover 257 back-to-back events -> seq wraps, so the 257th header has seq 8'h00 and sts_data=257, with 7-cycle spacing.
REQ-035 SHALL cover random m_axis_tready stalls over 100 events -> all 500 words match the model in order, data is stable during stalls, and s_axis_tready stays low while busy.
REQ-036 SHALL cover aresetn pulsed low after beat 2 is accepted -> m_axis_tvalid drops immediately, no further beats, next packet header seq=0, sts_data=0.
REQ-037 SHALL cover s_axis_tvalid held high continuously -> exactly one event is accepted per IDLE visit and none is double-counted.
